// File: rtl/is_prime_gates_sync.sv
// is_prime_gates_sync: 3-bit prime detector built from primitive gates, plus
// a one-cycle registered, valid-qualified copy and optional saturating stats.
// Ports: clk/rst (sync, active-high); c,b,a operand (c = MSB); in_valid qualifier;
//   prime (combinational), prime_q/out_valid (1-cycle registered),
//   prime_cnt/sample_cnt (CNT_W-bit saturating counters).
// Latency: prime is combinational; prime_q, out_valid and the counters lag by 1 cycle.
// Backpressure: none. An operand is accepted on every cycle that has in_valid = 1.
// Build option: define IS_PRIME_GATES_SYNC_STATS_EN to build the counters.
//   Without it, both counter outputs are tied to 0.
module is_prime_gates_sync #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c,
  input  logic             b,
  input  logic             a,
  input  logic             in_valid,
  output logic             prime,
  output logic             prime_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] prime_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  // prime = (~c & b) | (c & a)
  // Below 4 the primes are 2 and 3 (b set). From 4 up they are 5 and 7 (a set).
  logic c_n;
  logic lo_term;
  logic hi_term;

  not g_c_n    (c_n, c);
  and g_lo     (lo_term, c_n, b);
  and g_hi     (hi_term, c, a);
  or  g_prime  (prime, lo_term, hi_term);

  // Registered path. prime_q keeps its last value across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        prime_q <= prime;
      end
    end
  end

`ifdef IS_PRIME_GATES_SYNC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] prime_cnt_r;
  logic [CNT_W-1:0] sample_cnt_r;

  // Each counter saturates on its own. prime_cnt can never exceed sample_cnt,
  // so it keeps counting after sample_cnt has pinned at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt_r  <= '0;
      sample_cnt_r <= '0;
    end else if (in_valid) begin
      if (sample_cnt_r != CNT_MAX) begin
        sample_cnt_r <= sample_cnt_r + 1'b1;
      end
      if (prime && (prime_cnt_r != CNT_MAX)) begin
        prime_cnt_r <= prime_cnt_r + 1'b1;
      end
    end
  end

  assign prime_cnt  = prime_cnt_r;
  assign sample_cnt = sample_cnt_r;
`else
  assign prime_cnt  = '0;
  assign sample_cnt = '0;
`endif

endmodule

// File: tb/tb_is_prime_gates_sync.sv
module tb_is_prime_gates_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c = 1'b0, b = 1'b0, a = 1'b0;
  logic in_valid = 1'b0;

  logic       prime8, prime_q8, out_valid8;
  logic [7:0] prime_cnt8, sample_cnt8;
  logic       prime2, prime_q2, out_valid2;
  logic [1:0] prime_cnt2, sample_cnt2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

`ifdef IS_PRIME_GATES_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  is_prime_gates_sync #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .c(c), .b(b), .a(a), .in_valid(in_valid),
    .prime(prime8), .prime_q(prime_q8), .out_valid(out_valid8),
    .prime_cnt(prime_cnt8), .sample_cnt(sample_cnt8)
  );

  is_prime_gates_sync #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .c(c), .b(b), .a(a), .in_valid(in_valid),
    .prime(prime2), .prime_q(prime_q2), .out_valid(out_valid2),
    .prime_cnt(prime_cnt2), .sample_cnt(sample_cnt2)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_prime(input int v);
    return (v == 2) || (v == 3) || (v == 5) || (v == 7);
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (!STATS) return 0;
    return (n > mx) ? mx : n;
  endfunction

  bit m_pq = 1'b0;
  bit m_ov = 1'b0;
  int m_samples = 0;
  int m_primes  = 0;

  always @(posedge clk) begin
    int v;
    v = {c, b, a};
    if (rst) begin
      m_pq = 1'b0; m_ov = 1'b0; m_samples = 0; m_primes = 0;
    end else begin
      m_ov = in_valid;
      if (in_valid) begin
        m_pq = is_prime(v);
        m_samples++;
        if (is_prime(v)) m_primes++;
      end
    end
  end

  // One compare process, run every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp prime w8",      int'(prime8),      int'(is_prime({c, b, a})));
      check("cmp prime w2",      int'(prime2),      int'(is_prime({c, b, a})));
      check("cmp prime_q w8",    int'(prime_q8),    int'(m_pq));
      check("cmp prime_q w2",    int'(prime_q2),    int'(m_pq));
      check("cmp out_valid w8",  int'(out_valid8),  int'(m_ov));
      check("cmp out_valid w2",  int'(out_valid2),  int'(m_ov));
      check("cmp sample_cnt w8", int'(sample_cnt8), sat(m_samples, 8));
      check("cmp prime_cnt w8",  int'(prime_cnt8),  sat(m_primes, 8));
      check("cmp sample_cnt w2", int'(sample_cnt2), sat(m_samples, 2));
      check("cmp prime_cnt w2",  int'(prime_cnt2),  sat(m_primes, 2));
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs, take one rising edge, and return 1 ns after it.
  task automatic cyc(input logic r, input logic v, input int val);
    rst = r; in_valid = v; {c, b, a} = val[2:0];
    @(posedge clk);
    #1;
  endtask

  // Literal expectations for the registered outputs of the CNT_W = 8 instance.
  task automatic lit8(input string tag, input int pq, input int ov, input int sc, input int pc);
    check({tag, " prime_q"},    int'(prime_q8),    pq);
    check({tag, " out_valid"},  int'(out_valid8),  ov);
    check({tag, " sample_cnt"}, int'(sample_cnt8), STATS ? sc : 0);
    check({tag, " prime_cnt"},  int'(prime_cnt8),  STATS ? pc : 0);
  endtask

  initial begin
    int vals[5];
    int exp_tbl[8];
    int stream[3];
    int exp_pq[3];
    int exp_sc[3];
    int exp_pc[3];

    exp_tbl = '{0, 0, 1, 1, 0, 1, 0, 1};
    stream  = '{2, 4, 7};
    exp_pq  = '{1, 0, 1};
    exp_sc  = '{1, 2, 3};
    exp_pc  = '{1, 1, 2};
    vals    = '{2, 3, 5, 7, 2};

    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 0);
    chk_en = 1'b1;
    lit8("reset", 0, 0, 0, 0);

    // Sweep 0..7 with in_valid low, holding each value for one 10 ns period.
    for (int i = 0; i < 8; i++) begin
      rst = 1'b0; in_valid = 1'b0; {c, b, a} = 3'(i);
      #1;
      check($sformatf("sweep prime %0d", i), int'(prime8), exp_tbl[i]);
      @(posedge clk);
      #1;
    end
    lit8("after sweep", 0, 0, 0, 0);

    // Stream 2, 4, 7, then one idle cycle.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, stream[i]);
      lit8($sformatf("stream %0d", stream[i]), exp_pq[i], 1, exp_sc[i], exp_pc[i]);
    end
    cyc(1'b0, 1'b0, 0);
    lit8("idle", 1, 0, 3, 2);

    // Idle operand 5: prime follows at once, registered state is unchanged.
    rst = 1'b0; in_valid = 1'b0; {c, b, a} = 3'd5;
    #1;
    check("idle5 prime", int'(prime8), 1);
    @(posedge clk);
    #1;
    lit8("idle5", 1, 0, 3, 2);

    // Reset with a valid operand 3: the operand is discarded, prime still follows the inputs.
    rst = 1'b1; in_valid = 1'b1; {c, b, a} = 3'd3;
    #1;
    check("rst prime before edge", int'(prime8), 1);
    @(posedge clk);
    #1;
    check("rst prime after edge", int'(prime8), 1);
    lit8("rst with valid", 0, 0, 0, 0);

    // Five valid primes: the CNT_W = 2 instance pins at 3.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, vals[i]);
    check("sat sample_cnt w2", int'(sample_cnt2), STATS ? 3 : 0);
    check("sat prime_cnt w2",  int'(prime_cnt2),  STATS ? 3 : 0);
    lit8("five primes", 1, 1, 5, 5);

    // Two non-prime operands: only sample_cnt moves on the wide instance.
    cyc(1'b0, 1'b1, 4);
    cyc(1'b0, 1'b1, 6);
    check("sat hold sample_cnt w2", int'(sample_cnt2), STATS ? 3 : 0);
    lit8("after nonprimes", 0, 1, 7, 5);

    // Randomised traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
    end

    // Drive the wide counter past its old value after a reset, to restart from zero.
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 7);
    lit8("count from zero", 1, 1, 1, 1);

    cyc(1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/is_prime_gates_sync.md
# is_prime_gates_sync

Gate-level 3-bit prime detector with a registered output stage and optional running statistics. Decodes the unsigned value {c,b,a} (c = MSB) and flags the primes 2, 3, 5 and 7. It provides both an immediate combinational flag and a one-cycle registered, valid-qualified flag for synchronous consumers. It is a leaf block used wherever a small-operand primality flag is needed.

## Interface
- CNT_W, default 8: width of the statistics counters; legal range 2..32.

Ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset; synchronous, active-high.
- c, input, 1: operand bit 2 (MSB).
- b, input, 1: operand bit 1.
- a, input, 1: operand bit 0 (LSB).
- in_valid, input, 1: operand qualifier for the registered path and the statistics.
- prime, output, 1: combinational flag; 1 iff {c,b,a} ∈ {2,3,5,7}.
- prime_q, output, 1: registered copy of prime, captured when in_valid = 1.
- out_valid, output, 1: registered copy of in_valid.
- prime_cnt, output, CNT_W: saturating count of accepted operands that were prime.
- sample_cnt, output, CNT_W: saturating count of accepted operands.

## Operation
- Implement prime as a structural gate netlist (primitive and/or/not instances), not as a behavioural table: prime = (~c & b) | (c & a).
- Required truth table, value : prime:
  - 0 : 0
  - 1 : 0
  - 2 : 1
  - 3 : 1
  - 4 : 0
  - 5 : 1
  - 6 : 0
  - 7 : 1
- prime depends only on c, b and a. It is independent of clk, rst and in_valid.
- Registered path, on each rising clk edge:
  - out_valid ← in_valid.
  - If in_valid = 1: prime_q ← prime.
  - If in_valid = 0: prime_q holds its previous value.
- Statistics, on each rising clk edge when in_valid = 1:
  - sample_cnt increments by 1.
  - prime_cnt increments by 1 if prime = 1.
- Both counters saturate at 2^CNT_W − 1 and never wrap. At saturation, sample_cnt holds while prime_cnt continues until it also saturates.
- All arithmetic is unsigned.

## Timing
- prime has zero-cycle latency (combinational).
- prime_q, out_valid and the counters have a latency of exactly 1 cycle from the sampled inputs.
- There is no handshake backpressure; an operand is accepted on every cycle with in_valid = 1.
- On reset (rst = 1 at a rising edge):
  - prime_q = 0, out_valid = 0, prime_cnt = 0, sample_cnt = 0.
  - prime still follows the inputs.
- rst has priority over in_valid. An operand presented in the same cycle as rst is discarded and is not counted.
- Deasserting rst mid-stream lets the next valid operand be counted from zero.

## Configuration
- IS_PRIME_GATES_SYNC_STATS_EN:
  - When defined, prime_cnt and sample_cnt are implemented as specified above.
  - When undefined, the counter registers are not built and both outputs are tied to constant 0. The ports remain present, and prime, prime_q and out_valid are unaffected.

## Test plan
- Sweep {c,b,a} = 0..7 with 10 ns holds -> prime = 0,0,1,1,0,1,0,1, and all eight checks pass.
- Assert rst for one cycle with in_valid = 1 and {c,b,a} = 3 -> next cycle prime_q = 0, out_valid = 0, both counters 0, while prime = 1 throughout.
- Stream 2, 4, 7 with in_valid = 1, then idle with in_valid = 0 -> prime_q = 1, 0, 1 then holds 1; out_valid = 1, 1, 1, 0; sample_cnt = 3, prime_cnt = 2 (stats enabled).
- Set in_valid = 0 with {c,b,a} = 5 -> prime = 1 immediately; prime_q and both counters unchanged.
- CNT_W = 2 with 5 consecutive valid prime operands -> both counters saturate at 3 and stay at 3.
- Build without IS_PRIME_GATES_SYNC_STATS_EN and repeat the 2, 4, 7 stream -> counters stay 0; prime_q and out_valid sequences identical to the enabled build.
